if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013, the instruction word driven when the ID slot is empty.
REQ-002 The block SHALL have parameter HOLD_PC_LVL, default 3'd1, the minimum hold_flag_i value at which the PC register freezes.
REQ-003 The block SHALL have parameter HOLD_IF_LVL, default 3'd2, the minimum hold_flag_i value at which this block freezes its output; HOLD_IF_LVL >= HOLD_PC_LVL.
REQ-004 The block SHALL have ports, in order:
  clk_i  in  1  sole clock, all state on rising edge
  rst_i  in  1  asynchronous reset, active-high
  reboot_i  in  1  restart fetch; treated as a flush
  jump_flag_i  in  1  redirect taken this cycle; flush
  hold_flag_i  in  3  pipeline hold level
  fetch_pc_i  in  32  address presented to instruction memory this cycle
  fetch_instr_i  in  32  memory read data for the address issued the previous cycle (1-cycle synchronous read)
  id_pc_o  out  32  PC of instruction in ID slot
  id_instr_o  out  32  instruction in ID slot
  id_valid_o  out  1  ID slot holds a real instruction

Function
REQ-005 Internal state SHALL be: pending entry (pend_pc, pend_v), one-entry skid buffer (skid_pc, skid_instr, skid_v), and output slot (id_pc_o, id_instr_o, id_valid_o).
REQ-006 flush = reboot_i | jump_flag_i; pc_adv = (hold_flag_i < HOLD_PC_LVL); stall = (hold_flag_i >= HOLD_IF_LVL).
REQ-007 Each cycle: pend_pc <= fetch_pc_i; pend_v <= pc_adv & ~flush (an address counts as issued only in the last cycle it is presented).
REQ-008 fetch_instr_i SHALL be paired only with pend_pc and only when pend_v = 1; otherwise it is ignored.
REQ-009 Flush SHALL take priority over stall: id_valid_o <= 0, id_instr_o <= NOP_INSTR, id_pc_o holds, skid_v <= 0, pend_v <= 0.
REQ-010 No flush, no stall, skid_v = 1: output slot <= {skid_pc, skid_instr, 1}; skid_v <= 0.
REQ-011 No flush, no stall, skid_v = 0: output slot <= {pend_pc, fetch_instr_i, 1} if pend_v, else id_valid_o <= 0, id_instr_o <= NOP_INSTR, id_pc_o holds (bubble).
REQ-012 No flush, stall: output slot holds; if pend_v = 1 and skid_v = 0, skid <= {pend_pc, fetch_instr_i, 1}.
REQ-013 Skid and pend SHALL never both be valid (stall implies ~pc_adv, so pend_v is 0 the cycle after skid capture); if both valid, skid wins and pend is dropped; a simulation assertion SHALL flag it.
REQ-014 hold_flag_i in [HOLD_PC_LVL, HOLD_IF_LVL) SHALL produce bubbles in ID while the output keeps advancing.
REQ-015 Instruction order SHALL be preserved; no instruction duplicated or lost outside a flush.
REQ-016 Latency: address issued with pc_adv in cycle t appears on id_*_o in cycle t+2 absent stall/flush.

Reset
REQ-017 While rst_i = 1, asynchronously: id_pc_o = 0, id_instr_o = NOP_INSTR, id_valid_o = 0, pend_v = 0, skid_v = 0, pend_pc = skid_pc = 0, skid_instr = NOP_INSTR.
REQ-018 First edge after rst_i deasserts SHALL behave as a normal cycle; id_valid_o earliest 1 two edges after release.
REQ-019 Reset asserted mid-stall SHALL discard skid contents.

Verification
REQ-020 Stream: hold=0, fetch_pc 0x0,0x4,0x8, memory returns 0xA0,0xA4,0xA8 one cycle later -> id_pc/id_instr 0x0/0xA0, 0x4/0xA4, 0x8/0xA8 on consecutive cycles, valid=1.
REQ-021 Stall: after 0x4 issued, hold=2 for 3 cycles -> ID holds 0x0/0xA0, skid captures 0x4/0xA4; on release ID 0x4/0xA4 then 0x8/0xA8, no duplicate 0x4.
REQ-022 PC-only hold: hold=1 for 2 cycles -> two bubbles (valid=0, instr=0x13), then stream resumes in order.
REQ-023 Jump during stall: skid valid, jump_flag=1 with hold=2 -> next cycle valid=0, skid empty; target 0x100 reaches ID two cycles after jump.
REQ-024 Reset mid-operation: rst_i pulsed with valid=1 and skid_v=1 -> outputs immediately 0/0x13/0; no stale entry after release.
REQ-025 reboot_i=1 one cycle -> same response as jump flush.

Source files
------------

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg -- IF/ID pipeline register for a fetch stage driving a 1-cycle
// synchronous instruction memory.
//
// The fetch stage presents an address on fetch_pc_i.  The matching read data
// arrives on fetch_instr_i one cycle later.  This block pairs each returned
// word with the address that produced it. It then presents the pair to the
// decode stage through the ID output slot.
//
// Valid semantics: id_valid_o = 1 means id_pc_o/id_instr_o form a real
// instruction that decode may consume on the next rising edge.  There is no
// ready signal.  Back-pressure is expressed only through hold_flag_i:
//   hold_flag_i <  HOLD_PC_LVL : PC advances, ID advances
//   HOLD_PC_LVL <= hold_flag_i < HOLD_IF_LVL : PC frozen, ID advances (bubbles)
//   hold_flag_i >= HOLD_IF_LVL : PC frozen, ID frozen (stall)
// A flush (reboot_i or jump_flag_i) overrides any hold.
//
// Parameters:
//   NOP_INSTR   instruction word shown when the ID slot is empty
//   HOLD_PC_LVL minimum hold level that freezes the PC
//   HOLD_IF_LVL minimum hold level that freezes the ID slot. It must be
//               >= HOLD_PC_LVL.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous reset, active-high
//   reboot_i       restart fetch (flush)
//   jump_flag_i    redirect taken this cycle (flush)
//   hold_flag_i    pipeline hold level
//   fetch_pc_i     address presented to instruction memory this cycle
//   fetch_instr_i  read data for the address issued the previous cycle
//   id_pc_o        PC of the instruction in the ID slot
//   id_instr_o     instruction in the ID slot (NOP_INSTR when empty)
//   id_valid_o     ID slot holds a real instruction
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter logic [2:0]  HOLD_PC_LVL = 3'd1,
    parameter logic [2:0]  HOLD_IF_LVL = 3'd2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reboot_i,
    input  logic        jump_flag_i,
    input  logic [2:0]  hold_flag_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [31:0] fetch_instr_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        id_valid_o
);

    logic        flush;
    logic        pc_adv;
    logic        stall;

    // Address issued last cycle, whose read data is on fetch_instr_i now.
    logic [31:0] pend_pc;
    logic        pend_v;

    // One-entry skid buffer.  It catches the word returning while ID is stalled.
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        skid_v;

    assign flush  = reboot_i | jump_flag_i;
    assign pc_adv = (hold_flag_i < HOLD_PC_LVL);
    assign stall  = (hold_flag_i >= HOLD_IF_LVL);

    // An address counts as issued only if the PC moves past it this cycle.
    // A frozen PC re-presents the same address, and only its final
    // presentation is paired with data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_pc <= 32'h0;
            pend_v  <= 1'b0;
        end else begin
            pend_pc <= fetch_pc_i;
            pend_v  <= pc_adv & ~flush;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_pc    <= 32'h0;
            skid_instr <= NOP_INSTR;
            skid_v     <= 1'b0;
            id_pc_o    <= 32'h0;
            id_instr_o <= NOP_INSTR;
            id_valid_o <= 1'b0;
        end else if (flush) begin
            // Drop everything in flight.  The PC is kept so the output remains
            // stable while the slot is empty.
            skid_v     <= 1'b0;
            id_instr_o <= NOP_INSTR;
            id_valid_o <= 1'b0;
        end else if (!stall) begin
            if (skid_v) begin
                // The skid entry is older than anything pending.  If both are
                // valid, which cannot happen with HOLD_IF_LVL >= HOLD_PC_LVL,
                // the pending word is dropped.
                id_pc_o    <= skid_pc;
                id_instr_o <= skid_instr;
                id_valid_o <= 1'b1;
                skid_v     <= 1'b0;
            end else if (pend_v) begin
                id_pc_o    <= pend_pc;
                id_instr_o <= fetch_instr_i;
                id_valid_o <= 1'b1;
            end else begin
                id_instr_o <= NOP_INSTR;
                id_valid_o <= 1'b0;
            end
        end else begin
            // Stalled: the ID slot holds.  The word returning now would be
            // lost, so it is parked in the skid buffer.
            if (pend_v && !skid_v) begin
                skid_pc    <= pend_pc;
                skid_instr <= fetch_instr_i;
                skid_v     <= 1'b1;
            end
        end
    end

    // A stall freezes the PC, so pend_v is always low the cycle after a skid
    // capture.  Seeing both valid means the hold levels are misconfigured.
    a_skid_pend_exclusive: assert property (
        @(posedge clk_i) disable iff (rst_i) !(skid_v && pend_v)
    );

endmodule

// File: tb/tb_if_id_reg.sv
// -----------------------------------------------------------------------------
// tb_if_id_reg -- randomized scoreboard bench for if_id_reg.
//
// The driver changes inputs on the falling edge.  A reference model predicts
// the ID slot after the next rising edge and pushes that prediction into
// exp_q.  The model treats the block as an ordered queue of fetched
// instructions.  Each issued address returns one word a cycle later, and the
// word joins the queue.  An unstalled ID slot takes the oldest queued word or
// shows a bubble.  A flush empties everything.
//
// The monitor samples the outputs 1 time unit after each rising edge.  It
// pops one prediction and compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_if_id_reg;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [2:0]  HOLD_PC  = 3'd1;
    localparam logic [2:0]  HOLD_IF  = 3'd2;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        reboot_i;
    logic        jump_flag_i;
    logic [2:0]  hold_flag_i;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_instr_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_valid_o;

    always #5 clk_i = ~clk_i;

    if_id_reg #(
        .NOP_INSTR   (NOP),
        .HOLD_PC_LVL (HOLD_PC),
        .HOLD_IF_LVL (HOLD_IF)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .reboot_i      (reboot_i),
        .jump_flag_i   (jump_flag_i),
        .hold_flag_i   (hold_flag_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_instr_i (fetch_instr_i),
        .id_pc_o       (id_pc_o),
        .id_instr_o    (id_instr_o),
        .id_valid_o    (id_valid_o)
    );

    // ---------------- scoreboard state ----------------
    logic [64:0] exp_q[$];   // {valid, pc, instr}
    int          n_cmp = 0;
    int          n_err = 0;

    // ---------------- reference model state ----------------
    logic [63:0] m_q[$];     // fetched words not yet shown in ID: {pc, instr}
    logic [31:0] m_out_pc;
    logic [31:0] m_out_instr;
    logic        m_out_v;
    logic [31:0] m_inflight_pc;
    logic        m_inflight_v;
    logic [31:0] tb_pc;
    logic [31:0] j_target;

    function automatic logic [31:0] mem(input logic [31:0] pc);
        return pc + 32'hA0;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got v=%0b pc=%h instr=%h, expected v=%0b pc=%h instr=%h",
                     name, $time, act[64], act[63:32], act[31:0],
                     exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    // Predict the ID slot after the coming rising edge, using the current
    // inputs.
    task automatic model_edge();
        logic        flush;
        logic        adv;
        logic        stall;
        logic [63:0] e;
        if (rst_i) begin
            m_q.delete();
            m_out_pc      = 32'h0;
            m_out_instr   = NOP;
            m_out_v       = 1'b0;
            m_inflight_v  = 1'b0;
            m_inflight_pc = 32'h0;
            tb_pc         = 32'h0;
        end else begin
            flush = reboot_i | jump_flag_i;
            adv   = hold_flag_i < HOLD_PC;
            stall = hold_flag_i >= HOLD_IF;
            if (flush) begin
                m_q.delete();
                m_out_v     = 1'b0;
                m_out_instr = NOP;
            end else begin
                if (m_inflight_v) m_q.push_back({m_inflight_pc, mem(m_inflight_pc)});
                if (!stall) begin
                    if (m_q.size() > 0) begin
                        e           = m_q.pop_front();
                        m_out_pc    = e[63:32];
                        m_out_instr = e[31:0];
                        m_out_v     = 1'b1;
                    end else begin
                        m_out_v     = 1'b0;
                        m_out_instr = NOP;
                    end
                end
            end
            m_inflight_v  = adv && !flush;
            m_inflight_pc = fetch_pc_i;
            if (flush)    tb_pc = j_target;
            else if (adv) tb_pc = tb_pc + 32'd4;
        end
        exp_q.push_back({m_out_v, m_out_pc, m_out_instr});
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic rb, input logic j, input logic [2:0] h);
        @(negedge clk_i);
        rst_i         = r;
        reboot_i      = rb;
        jump_flag_i   = j;
        hold_flag_i   = h;
        fetch_pc_i    = tb_pc;
        // Memory answers the address issued last cycle.  When none was
        // issued, the bus carries junk that must be ignored.
        fetch_instr_i = m_inflight_v ? mem(m_inflight_pc) : $urandom();
        if (r) begin
            #1;
            check("async_rst", {id_valid_o, id_pc_o, id_instr_o}, {1'b0, 32'h0, NOP});
        end
        model_edge();
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [64:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("id_slot", {id_valid_o, id_pc_o, id_instr_o}, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] h;
        int         sel;
        rst_i         = 1'b1;
        reboot_i      = 1'b0;
        jump_flag_i   = 1'b0;
        hold_flag_i   = 3'd0;
        fetch_pc_i    = 32'h0;
        fetch_instr_i = 32'h0;
        tb_pc         = 32'h0;
        j_target      = 32'h100;
        m_inflight_v  = 1'b0;
        m_inflight_pc = 32'h0;
        m_out_pc      = 32'h0;
        m_out_instr   = NOP;
        m_out_v       = 1'b0;

        // reset, then plain stream 0x0/0xA0, 0x4/0xA4, ...
        repeat (2) step(1'b1, 1'b0, 1'b0, 3'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 3'd0);
        // full stall for 3 cycles, then release
        repeat (3) step(1'b0, 1'b0, 1'b0, 3'd2);
        repeat (3) step(1'b0, 1'b0, 1'b0, 3'd0);
        // PC-only hold gives two bubbles
        repeat (2) step(1'b0, 1'b0, 1'b0, 3'd1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 3'd0);
        // jump while the skid buffer is full, target 0x100
        step(1'b0, 1'b0, 1'b0, 3'd2);
        step(1'b0, 1'b0, 1'b1, 3'd2);
        repeat (4) step(1'b0, 1'b0, 1'b0, 3'd0);
        // reboot for one cycle
        j_target = 32'h200;
        step(1'b0, 1'b1, 1'b0, 3'd0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 3'd0);
        // reset while stalled with a valid slot and a full skid buffer
        step(1'b0, 1'b0, 1'b0, 3'd2);
        step(1'b1, 1'b0, 1'b0, 3'd2);
        repeat (4) step(1'b0, 1'b0, 1'b0, 3'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)       h = 3'd0;
            else if (sel < 7)  h = 3'd1;
            else if (sel < 9)  h = 3'd2;
            else               h = 3'($urandom_range(3, 7));
            j_target = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            step(1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 9) == 0),
                 h);
        end
        step(1'b0, 1'b0, 1'b0, 3'd0);

        // let the monitor consume the remaining predictions
        repeat (3) @(posedge clk_i);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
